sfft_stream_decoder: RTL and testbench



---
 rtl/sfft_pkg.sv | 27 ++
 rtl/sc_lane_counter.sv | 42 ++++
 rtl/sfft_stream_decoder.sv | 149 ++++++++++++++
 tb/tb_sfft_stream_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfft_pkg.sv
// Shared types and helpers for the stochastic FFT output decoder.
// Holds the window FSM state encoding, the window-length function and
// the saturating count-to-binary conversion used by every lane.
package sfft_pkg;

   // Decoder window state: waiting for a start, or accumulating a window.
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Window length in cycles for a given binary output width: N = 2^bw.
   function automatic int unsigned win_len(input int unsigned bw);
      return 32'd1 << bw;
   endfunction

   // Clamp a ones-count to the largest value a bw-bit word can hold.
   // A window of N all-one bits counts to N, one more than fits in bw bits,
   // so that single overflow case reads back as 2^bw-1.
   function automatic logic [31:0] saturate(input logic [31:0] count,
                                            input int unsigned bw);
      logic [31:0] lim;
      lim = (32'd1 << bw) - 32'd1;
      return (count > lim) ? lim : count;
   endfunction

endpackage

// File: rtl/sc_lane_counter.sv
// One lane of the bitstream decoder: counts ones over a window.
// The accumulator is one bit wider than the output word so that a full
// window of ones (N) is representable before saturation.
// The count output already includes the bit presented this cycle, so the
// parent can capture a complete result on the final window cycle without
// waiting an extra clock.
module sc_lane_counter
   import sfft_pkg::*;
#(
   parameter int BITWIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic                din,
   output logic [BITWIDTH-1:0] count
);

   logic [BITWIDTH:0] acc;
   logic [BITWIDTH:0] acc_next;

   // Running total including the current bit when counting is enabled.
   assign acc_next = acc + (BITWIDTH+1)'(en & din);

   // Saturated view of the running total, handed to the output register.
   assign count = BITWIDTH'(saturate(32'(acc_next), BITWIDTH));

   // Accumulator: clear wins over counting so a restart begins from zero.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments keep every lane sampling the same
      // pre-edge values regardless of block evaluation order.
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/sfft_stream_decoder.sv
// Output-side converter for the stochastic FFT datapath.
// Counts ones per lane of the real and imaginary bitstreams over a window of
// 2^BITWIDTH enabled cycles and presents the saturated counts as binary words
// behind a single-entry valid/ready output register. A result that completes
// while the previous one is still unaccepted is dropped and flagged sticky.
module sfft_stream_decoder
   import sfft_pkg::*;
#(
   parameter int BITWIDTH  = 8,
   parameter int NUMINPUTS = 2
) (
   input  logic                          iClk,
   input  logic                          iRst,
   input  logic                          iEn,
   input  logic                          iClr,
   input  logic                          iStart,
   input  logic [NUMINPUTS-1:0]          iReal,
   input  logic [NUMINPUTS-1:0]          iImg,
   input  logic                          iReady,
   output logic                          oValid,
   output logic [NUMINPUTS*BITWIDTH-1:0] oReal,
   output logic [NUMINPUTS*BITWIDTH-1:0] oImg,
   output logic                          oBusy,
   output logic                          oOverrun
);

   localparam int unsigned        N        = win_len(BITWIDTH);
   localparam logic [BITWIDTH-1:0] LAST_CNT = BITWIDTH'(N - 1);

   state_t                               state;
   state_t                               next_state;
   logic [BITWIDTH-1:0]                  wcnt;
   logic                                 accum_en;
   logic                                 last;
   logic                                 restart;
   logic                                 lane_clr;
   logic [NUMINPUTS-1:0][BITWIDTH-1:0]   re_sum;
   logic [NUMINPUTS-1:0][BITWIDTH-1:0]   im_sum;
   logic [NUMINPUTS-1:0][BITWIDTH-1:0]   re_q;
   logic [NUMINPUTS-1:0][BITWIDTH-1:0]   im_q;
   logic                                 valid_q;
   logic                                 overrun_q;

   // A bit is counted only in ACCUM with the enable high; stalls freeze all.
   assign accum_en = (state == ACCUM) && iEn;

   // Final window cycle: the N-th counted bit is being presented now.
   assign last = accum_en && (wcnt == LAST_CNT);

   // A window (re)starts from IDLE, or seamlessly from the final cycle.
   assign restart = iStart && ((state == IDLE) || last);

   // Lane accumulators are zeroed on clear or on entry to a new window.
   assign lane_clr = iClr || restart;

   // State register.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: clear dominates, a final cycle may chain a new window.
   always_comb begin
      // NOTE: next_state is defaulted before any branch so every path
      // assigns it and no latch is inferred.
      next_state = state;
      if (iClr) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:    if (iStart) next_state = ACCUM;
            ACCUM:   if (last)   next_state = iStart ? ACCUM : IDLE;
            default:             next_state = IDLE;
         endcase
      end
   end

   // Window counter: counts enabled cycles, restarts at zero per window.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         wcnt <= '0;
      end else if (lane_clr) begin
         wcnt <= '0;
      end else if (accum_en) begin
         wcnt <= wcnt + 1'b1;
      end
   end

   // Per-lane ones counters for the real and imaginary streams.
   for (genvar k = 0; k < NUMINPUTS; k++) begin : g_lane
      sc_lane_counter #(
         .BITWIDTH (BITWIDTH)
      ) u_re (
         .clk   (iClk),
         .rst   (iRst),
         .clr   (lane_clr),
         .en    (accum_en),
         .din   (iReal[k]),
         .count (re_sum[k])
      );

      sc_lane_counter #(
         .BITWIDTH (BITWIDTH)
      ) u_im (
         .clk   (iClk),
         .rst   (iRst),
         .clr   (lane_clr),
         .en    (accum_en),
         .din   (iImg[k]),
         .count (im_sum[k])
      );
   end

   // Output register with handshake and overrun: a load while a result is
   // still unaccepted drops the new data; a load during a handshake replaces it.
   always_ff @(posedge iClk or posedge iRst) begin
      // NOTE: the data words are reset as well, because oReal/oImg are
      // required to read zero straight out of reset.
      if (iRst) begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         re_q      <= '0;
         im_q      <= '0;
      end else if (iClr) begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else if (last) begin
         if (valid_q && !iReady) begin
            overrun_q <= 1'b1;
         end else begin
            valid_q <= 1'b1;
            re_q    <= re_sum;
            im_q    <= im_sum;
         end
      end else if (valid_q && iReady) begin
         valid_q <= 1'b0;
      end
   end

   assign oValid   = valid_q;
   assign oOverrun = overrun_q;
   assign oReal    = re_q;
   assign oImg     = im_q;
   assign oBusy    = (state == ACCUM);

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Directed self-checking bench for sfft_stream_decoder (BITWIDTH=8, NUMINPUTS=2).
// Cycle 0 is the cycle in which iStart is presented; outputs are sampled
// 1 time unit after each rising edge and inputs are driven at the same point.
module tb_sfft_stream_decoder;

   localparam int BW = 8;
   localparam int NI = 2;

   logic             iClk;
   logic             iRst;
   logic             iEn;
   logic             iClr;
   logic             iStart;
   logic [NI-1:0]    iReal;
   logic [NI-1:0]    iImg;
   logic             iReady;
   logic             oValid;
   logic [NI*BW-1:0] oReal;
   logic [NI*BW-1:0] oImg;
   logic             oBusy;
   logic             oOverrun;

   int total = 0;
   int bad   = 0;
   int valid_at;
   int busy_cnt;

   sfft_stream_decoder #(
      .BITWIDTH  (BW),
      .NUMINPUTS (NI)
   ) dut (
      .iClk     (iClk),
      .iRst     (iRst),
      .iEn      (iEn),
      .iClr     (iClr),
      .iStart   (iStart),
      .iReal    (iReal),
      .iImg     (iImg),
      .iReady   (iReady),
      .oValid   (oValid),
      .oReal    (oReal),
      .oImg     (oImg),
      .oBusy    (oBusy),
      .oOverrun (oOverrun)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Stimulus patterns for window cycle c (1-based):
   // 0 all ones; 1 lane pattern; 2 iEn toggling with ones only when enabled; else zeros.
   task automatic drive_bits(input int c, input int pat);
      case (pat)
         0: begin
            iEn = 1'b1; iReal = '1; iImg = '1;
         end
         1: begin
            iEn   = 1'b1;
            iReal = {1'b0, c[0]};
            iImg  = {1'b1, (c % 4 == 0)};
         end
         2: begin
            iEn   = c[0];
            iReal = {NI{c[0]}};
            iImg  = {NI{c[0]}};
         end
         default: begin
            iEn = 1'b1; iReal = '0; iImg = '0;
         end
      endcase
   endtask

   // Single window from IDLE; reports the cycle oValid first rose (-1 if
   // never within the budget) and how many cycles oBusy was high.
   task automatic run_window(input int pat, input int limit,
                             output int v_at, output int b_cnt);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      v_at   = -1;
      b_cnt  = 0;
      for (int c = 1; c <= limit; c++) begin
         if (oValid) begin
            v_at = c;
            break;
         end
         if (oBusy) b_cnt++;
         drive_bits(c, pat);
         tick();
      end
      drive_bits(0, 3);
   endtask

   // Two back-to-back windows with iStart held: window 1 all ones, window 2
   // using pat_b; iReady high only in cycle ready_cyc. Ends with an iClr pulse.
   task automatic back_to_back(input string pfx, input int pat_b, input int ready_cyc,
                               input logic [31:0] exp_real, input logic [31:0] exp_img,
                               input logic [31:0] exp_ovr);
      int drops;
      drops  = 0;
      iReady = 1'b0;
      iStart = 1'b1;
      tick();
      for (int c = 1; c <= 512; c++) begin
         if (c == 257) begin
            check({pfx, "_valid1"}, 32'(oValid), 32'd1);
            check({pfx, "_real1"}, 32'(oReal), 32'hFFFF);
            check({pfx, "_ovr1"}, 32'(oOverrun), 32'd0);
         end
         if (!oBusy) drops++;
         if (c <= 256) drive_bits(c, 0);
         else          drive_bits(c - 256, pat_b);
         iReady = (c == ready_cyc);
         tick();
      end
      iReady = 1'b0;
      check({pfx, "_busy_drops"}, 32'(drops), 32'd0);
      check({pfx, "_valid2"}, 32'(oValid), 32'd1);
      check({pfx, "_real2"}, 32'(oReal), exp_real);
      check({pfx, "_img2"}, 32'(oImg), exp_img);
      check({pfx, "_ovr2"}, 32'(oOverrun), exp_ovr);
      iStart = 1'b0;
      drive_bits(0, 3);
      iClr = 1'b1;
      tick();
      iClr = 1'b0;
      check({pfx, "_clr_valid"}, 32'(oValid), 32'd0);
      check({pfx, "_clr_ovr"}, 32'(oOverrun), 32'd0);
      check({pfx, "_clr_busy"}, 32'(oBusy), 32'd0);
      check({pfx, "_clr_keep"}, 32'(oReal), exp_real);
   endtask

   // Safety net so the run can never hang.
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      iRst = 1'b1; iEn = 1'b1; iClr = 1'b0; iStart = 1'b0;
      iReal = '0; iImg = '0; iReady = 1'b0;
      repeat (3) @(posedge iClk);
      #1;
      iRst = 1'b0;
      tick();

      // Reset state
      check("rst_valid", 32'(oValid), 32'd0);
      check("rst_busy", 32'(oBusy), 32'd0);
      check("rst_ovr", 32'(oOverrun), 32'd0);
      check("rst_real", 32'(oReal), 32'd0);
      check("rst_img", 32'(oImg), 32'd0);

      // All ones: oValid in cycle 257, busy in 1..256, saturated to 255
      run_window(0, 600, valid_at, busy_cnt);
      check("ones_valid_at", 32'(valid_at), 32'd257);
      check("ones_busy_cnt", 32'(busy_cnt), 32'd256);
      check("ones_busy_end", 32'(oBusy), 32'd0);
      check("ones_real", 32'(oReal), 32'hFFFF);
      check("ones_img", 32'(oImg), 32'hFFFF);
      iReady = 1'b1;
      tick();
      iReady = 1'b0;
      check("ones_ack_valid", 32'(oValid), 32'd0);
      check("ones_ack_ovr", 32'(oOverrun), 32'd0);

      // Lane pattern with iReady held: oReal={0,128}, oImg={255,64}
      iReady = 1'b1;
      run_window(1, 600, valid_at, busy_cnt);
      check("lane_valid_at", 32'(valid_at), 32'd257);
      check("lane_real", 32'(oReal), 32'h0080);
      check("lane_img", 32'(oImg), 32'hFF40);
      tick();
      iReady = 1'b0;
      check("lane_ack_valid", 32'(oValid), 32'd0);

      // iEn toggling: window stretches to 511 cycles, oValid in 512
      run_window(2, 600, valid_at, busy_cnt);
      check("stall_valid_at", 32'(valid_at), 32'd512);
      check("stall_busy_cnt", 32'(busy_cnt), 32'd511);
      check("stall_real", 32'(oReal), 32'hFFFF);
      check("stall_img", 32'(oImg), 32'hFFFF);
      iReady = 1'b1;
      tick();
      iReady = 1'b0;

      // Back-to-back, never ready: window 2 (zeros) dropped, overrun set
      back_to_back("b2b", 3, 0, 32'hFFFF, 32'hFFFF, 32'd1);

      // Back-to-back with iReady only in window 2's load cycle
      back_to_back("hs", 1, 512, 32'h0080, 32'hFF40, 32'd0);

      // Async reset at cycle 100 of a window
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      for (int c = 1; c <= 99; c++) begin
         drive_bits(c, 0);
         tick();
      end
      check("pre_rst_busy", 32'(oBusy), 32'd1);
      #2;
      iRst = 1'b1;
      #1;
      check("arst_busy", 32'(oBusy), 32'd0);
      check("arst_valid", 32'(oValid), 32'd0);
      check("arst_real", 32'(oReal), 32'd0);
      check("arst_img", 32'(oImg), 32'd0);
      check("arst_ovr", 32'(oOverrun), 32'd0);
      drive_bits(0, 3);
      tick();
      iRst = 1'b0;
      tick();
      check("post_rst_busy", 32'(oBusy), 32'd0);
      run_window(1, 600, valid_at, busy_cnt);
      check("post_rst_valid_at", 32'(valid_at), 32'd257);
      check("post_rst_real", 32'(oReal), 32'h0080);
      check("post_rst_img", 32'(oImg), 32'hFF40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
